// File: rtl/ioexp_input_debounce.sv
// Per-bit debouncer for an IO-expander input word: clean levels, edge strobes,
// and a small event queue of {polarity, bit index} with a level interrupt.
module ioexp_input_debounce #(
  parameter int               WIDTH          = 16,
  parameter int               TICK_DIV       = 1000,
  parameter int               DEBOUNCE_TICKS = 20,
  parameter int               FIFO_DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_valid,
  output logic [4:0]       evt_data,
  input  logic             evt_ready,
  output logic             evt_lost,
  input  logic             clear_lost,
  output logic             irq
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [PW-1:0]    presc_reg;
  logic             tick;
  logic [WIDTH-1:0] debounced_reg, rise_reg, fall_reg;
  logic [WIDTH-1:0] flip, rise_edge, fall_edge;
  logic [WIDTH-1:0] pend_r_reg, pend_f_reg, pend_r_next, pend_f_next;
  logic [WIDTH-1:0] drain_mask;
  logic             sel_valid, sel_pol;
  logic [3:0]       sel_idx;
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic             fifo_empty, fifo_full, push, pop, lost;
  logic             evt_lost_reg, irq_reg;
  logic [4:0]       mem [FIFO_DEPTH];

  assign tick = (presc_reg == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     presc_reg <= '0;
    else if (tick) presc_reg <= '0;
    else           presc_reg <= presc_reg + 1'b1;
  end

  // A bit's counter only advances while raw disagrees with the clean level.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_inc;
    logic          differs;

    assign differs   = (raw_in[gi] != debounced_reg[gi]);
    assign cnt_inc   = cnt_reg + 1'b1;
    assign flip[gi]  = tick && differs && (cnt_inc == CW'(DEBOUNCE_TICKS));

    always_ff @(posedge clk) begin
      if (reset)                   cnt_reg <= '0;
      else if (!differs || flip[gi]) cnt_reg <= '0;
      else if (tick)               cnt_reg <= cnt_inc;
    end
  end

  assign rise_edge = flip & ~debounced_reg;
  assign fall_edge = flip & debounced_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      debounced_reg <= RESET_VALUE;
      rise_reg      <= '0;
      fall_reg      <= '0;
    end else begin
      debounced_reg <= debounced_reg ^ flip;
      rise_reg      <= rise_edge;
      fall_reg      <= fall_edge;
    end
  end

  // Lowest pending index wins; scanning downward leaves the smallest one last.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_pol   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_r_reg[i] || pend_f_reg[i]) begin
        sel_valid = 1'b1;
        sel_idx   = 4'(i);
        sel_pol   = pend_r_reg[i];
      end
    end
  end

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop        = !fifo_empty && evt_ready;
  assign push       = sel_valid && (!fifo_full || pop);
  assign drain_mask = push ? (WIDTH'(1) << sel_idx) : '0;

  // A new edge overrides both a drain and an opposite pending edge on its bit.
  assign pend_r_next = (pend_r_reg & ~drain_mask & ~fall_edge) | rise_edge;
  assign pend_f_next = (pend_f_reg & ~drain_mask & ~rise_edge) | fall_edge;
  assign lost        = |(((fall_edge & pend_r_reg) | (rise_edge & pend_f_reg)) & ~drain_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r_reg   <= '0;
      pend_f_reg   <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      evt_lost_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      pend_r_reg <= pend_r_next;
      pend_f_reg <= pend_f_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (lost)            evt_lost_reg <= 1'b1;
      else if (clear_lost) evt_lost_reg <= 1'b0;
      irq_reg <= !fifo_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= {sel_pol, sel_idx};
  end

  assign debounced = debounced_reg;
  assign rise      = rise_reg;
  assign fall      = fall_reg;
  assign evt_valid = !fifo_empty;
  assign evt_data  = mem[rd_ptr_reg[AW-1:0]];
  assign evt_lost  = evt_lost_reg;
  assign irq       = irq_reg;

endmodule
